hilo_muldiv_unit: RTL and testbench

- Parametrised successor to the single-register Hi/Lo pair.
- Holds HI and LO and writes them directly for MTHI/MTLO.
- Also runs iterative MULT/MULTU/DIV/DIVU, one bit per cycle, and drives a busy stall toward the ID stage.
- Sits beside the EX-stage ALU; HI/LO are read combinationally by MFHI/MFLO.

---
 rtl/hilo_muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO register pair with iterative multiply/divide, one bit per cycle
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] pw,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t               r_state, w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_a;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_is_div, r_dz, r_sign_s, r_sign_t;
    logic [WIDTH-1:0]     r_hi, r_lo;
    logic                 r_busy, r_done, r_dbz;

    logic                 w_launch, w_signed, w_rs_neg, w_rt_neg, w_div_zero;
    logic [WIDTH-1:0]     w_rs_mag, w_rt_mag;
    logic [WIDTH:0]       w_sum, w_shift, w_sub;
    logic                 w_ge;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot, w_rem;

    assign w_launch   = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_signed   = ~op[0];
    assign w_rs_neg   = w_signed & rs_val[WIDTH-1];
    assign w_rt_neg   = w_signed & rt_val[WIDTH-1];
    assign w_rs_mag   = w_rs_neg ? -rs_val : rs_val;
    assign w_rt_mag   = w_rt_neg ? -rt_val : rt_val;
    assign w_div_zero = op[1] && (rt_val == '0);

    // Multiply: upper half accumulates, multiplier bits shift out of the low end.
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_sub   = w_shift - {1'b0, r_a};
    assign w_ge    = ~w_sub[WIDTH];

    assign w_prod  = (r_sign_s ^ r_sign_t) ? -r_acc : r_acc;
    assign w_quot  = (r_sign_s ^ r_sign_t) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem   = r_sign_s ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_launch) begin
                    if (w_div_zero)  w_next = S_FIX;
                    else if (op[1])  w_next = S_DIV;
                    else             w_next = S_MUL;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_MUL, S_DIV: if (r_cnt == '0) w_next = S_FIX;
            S_FIX:        w_next = S_DONE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_acc    <= '0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_sign_s <= 1'b0;
            r_sign_t <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_busy <= (w_next == S_MUL) || (w_next == S_DIV) || (w_next == S_FIX);
            r_done <= (w_next == S_DONE);
            r_dbz  <= (w_next == S_DONE) && r_dz;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_launch) begin
                        r_cnt    <= CNT_W'(WIDTH - 1);
                        r_is_div <= op[1];
                        r_dz     <= w_div_zero;
                        r_sign_s <= w_rs_neg;
                        r_sign_t <= w_rt_neg;
                        if (op[1]) begin
                            r_a   <= w_rt_mag;
                            r_acc <= {{WIDTH{1'b0}}, w_rs_mag};
                        end else begin
                            r_a   <= w_rs_mag;
                            r_acc <= {{WIDTH{1'b0}}, w_rt_mag};
                        end
                    end else begin
                        if (hi_we) r_hi <= pw;
                        if (lo_we) r_lo <= pw;
                    end
                end
                S_MUL: begin
                    r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_DIV: begin
                    r_acc <= {(w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0]),
                              r_acc[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIX: begin
                    if (!r_dz) begin
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi_out      = r_hi;
    assign lo_out      = r_lo;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - directed self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset, start, hi_we, lo_we;
    logic [1:0]    op;
    logic [W-1:0]  rs_val, rt_val, pw;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi_out, lo_out;

    int checks   = 0;
    int failures = 0;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we), .pw(pw),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input int ebusy, input logic edbz, input bit we_with_start,
                          input bit disturb);
        int n;
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        hi_we = we_with_start; lo_we = we_with_start; pw = 32'hDEAD0000;
        tick;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (disturb && n == 5) begin
                start = 1'b1; op = 2'b01; rs_val = 32'h3; rt_val = 32'h3;
                hi_we = 1'b1; lo_we = 1'b1; pw = 32'hDEADBEEF;
            end else if (disturb && n == 6) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            tick;
        end
        check({tag, "_busy_cycles"}, n, ebusy);
        check({tag, "_done"}, done, 1);
        check({tag, "_dbz"}, div_by_zero, edbz);
        check({tag, "_hi"}, hi_out, eh);
        check({tag, "_lo"}, lo_out, el);
        tick;
        check({tag, "_done_clr"}, {done, div_by_zero, busy}, 3'b000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; rs_val = '0; rt_val = '0; pw = '0;
        tick; tick;
        check("rst_state", {busy, done, div_by_zero, hi_out, lo_out}, '0);
        reset = 1'b0;
        tick;

        hi_we = 1'b1; pw = 32'h12345678;
        tick;
        hi_we = 1'b0;
        check("mthi_hi", hi_out, 32'h12345678);
        check("mthi_lo", lo_out, 32'h0);
        hi_we = 1'b1; lo_we = 1'b1; pw = 32'h0F0F0F0F;
        tick;
        hi_we = 1'b0; lo_we = 1'b0;
        check("both_we", {hi_out, lo_out}, 64'h0F0F0F0F_0F0F0F0F);

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 0, 0, 0);
        run_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33, 0, 0, 0);
        run_op("mult_min",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 0, 0, 0);
        run_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0, 0, 0);
        run_op("divu_7_2",  2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 33, 0, 0, 0);
        run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 0, 0, 0);

        hi_we = 1'b1; pw = 32'hAA;
        tick;
        hi_we = 1'b0; lo_we = 1'b1; pw = 32'hBB;
        tick;
        lo_we = 1'b0;
        run_op("divu_zero", 2'b11, 32'h00001234, 32'h0, 32'hAA, 32'hBB, 1, 1, 1, 0);

        run_op("disturb", 2'b01, 32'h00010000, 32'h00010003, 32'h00000001, 32'h00030000, 33, 0, 0, 1);

        op = 2'b00; rs_val = 32'd7; rt_val = 32'd9; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        check("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_outs", {busy, done, hi_out, lo_out}, '0);
        reset = 1'b0;
        n = 0;
        repeat (40) begin
            tick;
            if (done === 1'b1 || busy === 1'b1) n++;
        end
        check("post_rst_quiet", n, 0);
        run_op("after_rst", 2'b00, 32'd7, 32'hFFFFFFF7, 32'hFFFFFFFF, 32'hFFFFFFC1, 33, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
